// File: rtl/ring_arb_pkg.sv
// Package: ring_arb_pkg
// Shared state encoding and helpers for the ring round-robin arbiter.
//  - state_t / IDLE / HOLD : arbiter FSM state
//  - rotl1                 : rotate a one-hot vector of width n left by one (wraps)
//  - onehot_to_idx         : index of the set bit of a one-hot vector
// Helpers operate on MAX_N-wide vectors; callers size-cast to their own width.
package ring_arb_pkg;

  localparam int unsigned MAX_N = 32;

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t HOLD = 1'b1;

  function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] v, input int n);
    logic [MAX_N-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) r[(i + 1) % n] = v[i];
    end
    return r;
  endfunction

  function automatic int unsigned onehot_to_idx(input logic [MAX_N-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (v[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ring_ptr_reg.sv
// Module: ring_ptr_reg
// N-bit one-hot ring register holding the arbiter priority token.
//  clk     in  1  clock
//  reset   in  1  synchronous active-high reset, loads bit0
//  load    in  1  when high, register takes rot_val rotated left by one
//  rot_val in  N  one-hot value to rotate from (the grant being released)
//  ptr     out N  current one-hot priority pointer
module ring_ptr_reg
  import ring_arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] rot_val,
  output logic [N-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= N'(1);
    end else if (load) begin
      ptr <= N'(rotl1(MAX_N'(rot_val), N));
    end
  end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Module: ring_rr_arbiter
// Round-robin arbiter for one shared resource; one-hot ring pointer as the
// priority token, bounded hold time, priority rotates past the last owner.
//  clk     in  1          clock, posedge
//  reset   in  1          synchronous active-high reset
//  req     in  N          level requests, held until done
//  done    in  N          release pulse; only done[owner] is looked at
//  grant   out N          registered one-hot grant, 0 when idle
//  busy    out 1          |grant
//  owner   out clog2(N)   index of current/last owner
//  timeout out 1          one-cycle pulse after a hold-limit-only release
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         grant,
  output logic                 busy,
  output logic [$clog2(N)-1:0] owner,
  output logic                 timeout
);

  localparam int unsigned OW = $clog2(N);
  localparam int unsigned CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [OW-1:0] owner_q, owner_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  ptr;
  logic          ptr_load;

  ring_ptr_reg #(
    .N (N)
  ) u_ptr (
    .clk     (clk),
    .reset   (reset),
    .load    (ptr_load),
    .rot_val (grant_q),
    .ptr     (ptr)
  );

  // Priority search: lower copy keeps only bits at/above ptr, upper copy is
  // the wrapped-around remainder, so the lowest set bit is the winner.
  logic [2*N-1:0] dreq;
  logic [OW-1:0]  pick_idx;
  logic           pick_found;

  assign dreq = {req, req & ~(ptr - N'(1))};

  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (dreq[i]) begin
        pick_found = 1'b1;
        pick_idx   = (i >= int'(N)) ? OW'(i - int'(N)) : OW'(i);
      end
    end
  end

  logic rel_done, rel_drop, rel_lim;
  assign rel_done = done[owner_q];
  assign rel_drop = ~req[owner_q];
  assign rel_lim  = (cnt_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    ptr_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = N'(1) << pick_idx;
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (rel_done || rel_drop || rel_lim) begin
          grant_d   = '0;
          cnt_d     = '0;
          state_d   = IDLE;
          ptr_load  = 1'b1;
          // A cooperative release on the limit edge is not a timeout.
          timeout_d = rel_lim & ~rel_done & ~rel_drop;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = |grant_q;
  assign owner   = owner_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Bench for ring_rr_arbiter (N=4, MAX_HOLD=8): directed scenarios with
// literal expectations plus a cycle-level behavioural model compared every
// cycle, followed by a short pseudo-random stretch.
module tb_ring_rr_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] done;
  logic [N-1:0] grant;
  logic         busy;
  logic [1:0]   owner;
  logic         timeout;

  int n_total;
  int n_pass;

  ring_rr_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .busy    (busy),
    .owner   (owner),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: who owns the resource, for how many cycles so far,
  // and which index has top priority next.
  int m_ptr;
  int m_owner;
  int m_cycles;
  bit m_busy;
  bit m_to;

  task automatic model_step();
    m_to = 1'b0;
    if (reset) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cycles = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!m_busy && req[j]) begin
          m_busy = 1'b1; m_owner = j; m_cycles = 1;
        end
      end
    end else begin
      if (done[m_owner] || !req[m_owner]) begin
        m_busy = 1'b0; m_ptr = (m_owner + 1) % N;
      end else if (m_cycles == MAX_HOLD) begin
        m_busy = 1'b0; m_ptr = (m_owner + 1) % N; m_to = 1'b1;
      end else begin
        m_cycles++;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("m_grant", 32'(grant), m_busy ? 32'(1 << m_owner) : 32'd0);
      check("m_busy", 32'(busy), 32'(m_busy));
      check("m_owner", 32'(owner), 32'(m_owner));
      check("m_timeout", 32'(timeout), 32'(m_to));
      check("m_ptr", 32'(dut.u_ptr.ptr), 32'(1 << m_ptr));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [N-1:0] exp_seq [5];

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset = 1'b1; req = '0; done = '0;

    // 1: reset state
    tick(2);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    check("rst_ptr", 32'(dut.u_ptr.ptr), 32'h1);
    reset = 1'b0;

    // 2: single requester, done after 3 cycles
    req = 4'b0001;
    tick(1);
    check("t2_grant", 32'(grant), 32'h1);
    tick(2);
    done = 4'b0001;
    tick(1);
    done = '0; req = '0;
    check("t2_release", 32'(grant), 32'h0);
    check("t2_ptr", 32'(dut.u_ptr.ptr), 32'h2);
    check("t2_timeout", 32'(timeout), 32'h0);

    // 3: all requesting, done in each grant's second cycle
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    req = 4'b1111;
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("t3_grant", 32'(grant), 32'(exp_seq[i]));
      tick(1);
      done = 4'b1111;
      tick(1);
      done = '0;
      check("t3_gap", 32'(grant), 32'h0);
    end
    req = '0;
    tick(1);

    // 4: requester 2 never releases -> 8-cycle limit and timeout pulse
    req = 4'b0100;
    tick(1);
    for (int i = 0; i < MAX_HOLD; i++) begin
      check("t4_held", 32'(grant), 32'h4);
      tick(1);
    end
    check("t4_revoked", 32'(grant), 32'h0);
    check("t4_timeout", 32'(timeout), 32'h1);
    check("t4_ptr", 32'(dut.u_ptr.ptr), 32'h8);
    req = '0;
    tick(1);
    check("t4_pulse_end", 32'(timeout), 32'h0);

    // 5: owner 3 drops req; then done coincides with limit
    req = 4'b1000;
    tick(1);
    check("t5_grant", 32'(grant), 32'h8);
    check("t5_owner", 32'(owner), 32'h3);
    tick(2);
    req = '0;
    tick(1);
    check("t5_drop", 32'(grant), 32'h0);
    check("t5_drop_to", 32'(timeout), 32'h0);
    check("t5_ptr", 32'(dut.u_ptr.ptr), 32'h1);
    req = 4'b0001;
    tick(1);
    check("t5_grant0", 32'(grant), 32'h1);
    tick(MAX_HOLD - 1);
    done = 4'b0001;
    tick(1);
    done = '0;
    check("t5_lim_done", 32'(grant), 32'h0);
    check("t5_lim_done_to", 32'(timeout), 32'h0);

    // 6: reset during HOLD
    req = 4'b1111;
    tick(1);
    check("t6_grant", 32'(grant), 32'h2);
    tick(1);
    reset = 1'b1;
    tick(1);
    check("t6_rst_grant", 32'(grant), 32'h0);
    check("t6_rst_to", 32'(timeout), 32'h0);
    reset = 1'b0;
    tick(1);
    check("t6_first", 32'(grant), 32'h1);
    req = '0;
    tick(2);

    // Pseudo-random stretch, checked by the model only
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      tick(1);
    end
    req = '0; done = '0;
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
